// File: rtl/prom_loader.sv
// Byte-stream loader for a 16 x 15-bit program memory: two bytes per word, one write strobe per word.
// Optional trailing checksum byte enabled by defining PROM_LOADER_CHECKSUM_EN.
module prom_loader #(
    parameter int unsigned WORDS = 16
) (
    input  logic        CLK_FT,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic        WR_EN,
    output logic [3:0]  WR_ADDR,
    output logic [14:0] WR_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam int unsigned AW = 4;
    localparam int unsigned HW = 7;
    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  addr_q;
    logic [HW-1:0]  hi_q;
    logic [14:0]    wr_data_q;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           wr_en_q, wr_en_d;
    logic           accept;
    logic           start_go;

    assign accept   = RX_VALID && ready_q;
    assign start_go = START && ((state_q == S_IDLE) || (state_q == S_DONE));

    // State register
    always_ff @(posedge CLK_FT or negedge RESET_N) begin
        if (!RESET_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_go) state_d = S_HI;
            S_HI:           if (accept)   state_d = S_LO;
            S_LO:           if (accept)   state_d = S_WRITE;
            S_WRITE: begin
                if (addr_q < LAST) state_d = S_HI;
`ifdef PROM_LOADER_CHECKSUM_EN
                else               state_d = S_CSUM;
`else
                else               state_d = S_DONE;
`endif
            end
`ifdef PROM_LOADER_CHECKSUM_EN
            S_CSUM:         if (accept)   state_d = S_DONE;
`endif
            default:        state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered flags line up with state_q
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wr_en_d = 1'b0;
        case (state_d)
            S_HI, S_LO, S_CSUM: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_WRITE: begin
                busy_d  = 1'b1;
                wr_en_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK_FT or negedge RESET_N) begin
        if (!RESET_N) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_en_q <= wr_en_d;
        end
    end

    // Address only advances when another word follows, so it ends at WORDS-1
    always_ff @(posedge CLK_FT or negedge RESET_N) begin
        if (!RESET_N) begin
            addr_q    <= '0;
            hi_q      <= '0;
            wr_data_q <= '0;
        end else begin
            if (start_go)
                addr_q <= '0;
            else if ((state_q == S_WRITE) && (state_d == S_HI))
                addr_q <= addr_q + AW'(1);
            if ((state_q == S_HI) && accept)
                hi_q <= RX_DATA[HW-1:0];
            if ((state_q == S_LO) && accept)
                wr_data_q <= {hi_q, RX_DATA};
        end
    end

`ifdef PROM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       err_q;

    // Running sum covers the full HI byte, including the bit dropped from the word
    always_ff @(posedge CLK_FT or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (start_go) begin
                sum_q <= '0;
                err_q <= 1'b0;
            end else if (accept && ((state_q == S_HI) || (state_q == S_LO))) begin
                sum_q <= sum_q + RX_DATA;
            end else if (accept && (state_q == S_CSUM)) begin
                err_q <= (RX_DATA != sum_q);
            end
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign RX_READY = ready_q;
    assign WR_EN    = wr_en_q;
    assign WR_ADDR  = addr_q;
    assign WR_DATA  = wr_data_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_prom_loader.sv
// Directed self-checking bench for prom_loader (WORDS=16); checksum cases run when PROM_LOADER_CHECKSUM_EN is defined.
module tb_prom_loader;

    logic        CLK_FT = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        WR_EN;
    logic [3:0]  WR_ADDR;
    logic [14:0] WR_DATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    prom_loader #(.WORDS(16)) u_dut (
        .CLK_FT   (CLK_FT),
        .RESET_N  (RESET_N),
        .START    (START),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK_FT = ~CLK_FT;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int base;
    logic [3:0]  log_addr [128];
    logic [14:0] log_data [128];
    int          log_cyc  [128];
    logic [7:0]  tx_hi [16];
    logic [7:0]  tx_lo [16];
`ifdef PROM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_m;
    bit          bad_trailer = 1'b0;
`endif

    always @(posedge CLK_FT) cyc <= cyc + 1;

    // Record every write strobe away from the active edge
    always @(negedge CLK_FT) begin
        if (WR_EN && n_wr < 128) begin
            log_addr[n_wr] <= WR_ADDR;
            log_data[n_wr] <= WR_DATA;
            log_cyc[n_wr]  <= cyc;
            n_wr           <= n_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_FT);
        #1;
    endtask

    // Present a byte and hold it until the handshake completes (bounded)
    task automatic put(input logic [7:0] b, input bit stall);
        bit ok;
        if (stall) begin
            RX_VALID = 1'b0;
            RX_DATA  = 8'hEE;
            tick();
        end
        RX_DATA  = b;
        RX_VALID = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (RX_READY) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("rx_timeout", 32'(0), 32'(1));
`ifdef PROM_LOADER_CHECKSUM_EN
        sum_m = sum_m + b;
`endif
    endtask

    task automatic do_start();
        base  = n_wr;
        START = 1'b1;
        tick();
        START = 1'b0;
`ifdef PROM_LOADER_CHECKSUM_EN
        sum_m = 8'h00;
`endif
    endtask

    task automatic load(input int nw, input bit stall, input int start_at);
        for (int i = 0; i < nw; i++) begin
            if (i == start_at) START = 1'b1;
            put(tx_hi[i], stall);
            START = 1'b0;
            put(tx_lo[i], stall);
            check($sformatf("wr_en_after_lo%0d", i), 32'(WR_EN), 32'(1));
            check($sformatf("wr_addr_at_wr%0d", i), 32'(WR_ADDR), 32'(i));
        end
    endtask

    task automatic finish_session();
`ifdef PROM_LOADER_CHECKSUM_EN
        put(sum_m + 8'(bad_trailer), 1'b0);
`endif
        RX_VALID = 1'b0;
        tick();
        check("done_set", 32'(DONE), 32'(1));
        check("busy_clr", 32'(BUSY), 32'(0));
`ifdef PROM_LOADER_CHECKSUM_EN
        check("err_flag", 32'(ERR), 32'(bad_trailer));
`else
        check("err_flag", 32'(ERR), 32'(0));
`endif
    endtask

    task automatic set_full_table();
        for (int i = 0; i < 16; i++) begin
            tx_hi[i] = (i == 0) ? 8'h48 : 8'h40;
            tx_lo[i] = 8'(i);
        end
    endtask

    task automatic set_zero_table();
        for (int i = 0; i < 16; i++) begin
            tx_hi[i] = 8'h00;
            tx_lo[i] = 8'h00;
        end
    endtask

    initial begin
        RESET_N  = 1'b0;
        START    = 1'b0;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        #1;
        check("reset_outputs", 32'({RX_READY, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERR}), 32'(0));
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        check("idle_busy", 32'(BUSY), 32'(0));
        check("idle_ready", 32'(RX_READY), 32'(0));
        check("idle_done", 32'(DONE), 32'(0));

        // Full load, RX_VALID continuously high
        set_full_table();
        do_start();
        check("start_busy", 32'(BUSY), 32'(1));
        check("start_ready", 32'(RX_READY), 32'(1));
        load(16, 1'b0, -1);
        finish_session();
        check("full_count", 32'(n_wr - base), 32'(16));
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_addr%0d", i), 32'(log_addr[base+i]), 32'(i));
            check($sformatf("full_data%0d", i), 32'(log_data[base+i]),
                  (i == 0) ? 32'h4800 : 32'h4000 + 32'(i));
            if (i > 0)
                check($sformatf("full_gap%0d", i), 32'(log_cyc[base+i] - log_cyc[base+i-1]), 32'(3));
        end
        repeat (3) tick();
        check("done_hold", 32'(DONE), 32'(1));
        check("busy_hold", 32'(BUSY), 32'(0));
        check("final_addr", 32'(WR_ADDR), 32'(15));
        check("data_hold", 32'(WR_DATA), 32'h400F);

        // Handshake stalls with garbage while RX_VALID is low
        set_zero_table();
        tx_hi[0] = 8'h12;
        tx_lo[0] = 8'h34;
        do_start();
        load(16, 1'b1, -1);
        finish_session();
        check("stall_count", 32'(n_wr - base), 32'(16));
        check("stall_data0", 32'(log_data[base]), 32'h1234);
        check("stall_addr0", 32'(log_addr[base]), 32'(0));
        check("stall_data15", 32'(log_data[base+15]), 32'h0000);

        // Bit-7 masking, and START pulsed while busy during word 2
        set_zero_table();
        tx_hi[0] = 8'hFF;
        tx_lo[0] = 8'h00;
        tx_hi[1] = 8'h80;
        tx_lo[1] = 8'hAB;
        do_start();
        load(16, 1'b0, 2);
        finish_session();
        check("mask_count", 32'(n_wr - base), 32'(16));
        check("mask_data0", 32'(log_data[base]), 32'h7F00);
        check("mask_data1", 32'(log_data[base+1]), 32'h00AB);
        for (int i = 0; i < 16; i++)
            check($sformatf("busy_start_addr%0d", i), 32'(log_addr[base+i]), 32'(i));

        // Reset mid-session after word 5
        set_full_table();
        do_start();
        load(6, 1'b0, -1);
        RX_VALID = 1'b0;
        tick();
        #2;
        RESET_N = 1'b0;
        #1;
        check("midrst_outputs", 32'({RX_READY, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERR}), 32'(0));
        tick();
        tick();
        RESET_N  = 1'b1;
        RX_VALID = 1'b1;
        RX_DATA  = 8'h55;
        repeat (5) tick();
        check("midrst_no_wr", 32'(n_wr - base), 32'(6));
        check("midrst_busy", 32'(BUSY), 32'(0));
        check("midrst_ready", 32'(RX_READY), 32'(0));
        RX_VALID = 1'b0;
        tick();
        do_start();
        load(16, 1'b0, -1);
        finish_session();
        check("reload_count", 32'(n_wr - base), 32'(16));
        check("reload_addr0", 32'(log_addr[base]), 32'(0));
        check("reload_data0", 32'(log_data[base]), 32'h4800);

`ifdef PROM_LOADER_CHECKSUM_EN
        // Wrong trailer: sum of 0x01+0x02 is 0x03, send 0x04
        set_zero_table();
        tx_hi[0] = 8'h01;
        tx_lo[0] = 8'h02;
        bad_trailer = 1'b1;
        do_start();
        load(16, 1'b0, -1);
        finish_session();
        bad_trailer = 1'b0;
        do_start();
        check("err_cleared_on_start", 32'(ERR), 32'(0));
        load(16, 1'b0, -1);
        finish_session();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
